// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives the shared-ALU,
// single-memory datapath with configurable memory wait states, optional BNE and illegal-op flag.
module multicycle_control_unit #(
  parameter int unsigned MEM_LAT  = 2,
  parameter bit          BNE_EN   = 1'b1,
  parameter int unsigned OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNe,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                InstrDone,
  output logic                Illegal,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StBne    = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [3:0] CntLast = 4'(MEM_LAT);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [5:0] w_op;
  logic       w_hi_zero;
  logic       w_last;
  logic       w_unused_zero;

  assign w_op   = Opcode[5:0];
  assign w_last = (r_cnt == CntLast);

  // The branch decision is made in the datapath; the FSM only selects the condition.
  assign w_unused_zero = Zero;

  // Any set bit above the 6-bit decoded field makes the opcode unsupported.
  if (OPCODE_W > 6) begin : g_hi_bits
    assign w_hi_zero = ~|Opcode[OPCODE_W-1:6];
  end else begin : g_no_hi_bits
    assign w_hi_zero = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    BranchNe     = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    InstrDone    = 1'b0;
    Illegal      = 1'b0;
    State        = r_state;

    case (r_state)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (w_last) begin
          IRWrite      = 1'b1;
          PCWrite      = 1'b1;
          w_state_next = StDecode;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StDecode: begin
        // Precompute the branch target into ALUOut while the opcode is decoded.
        ALUSrcB      = 2'b11;
        w_state_next = StFetch;
        if (!w_hi_zero) begin
          Illegal = 1'b1;
        end else begin
          case (w_op)
            OpLw, OpSw: w_state_next = StMemAdr;
            OpRtype:    w_state_next = StExec;
            OpBeq:      w_state_next = StBeq;
            OpBne: begin
              if (BNE_EN) w_state_next = StBne;
              else        Illegal      = 1'b1;
            end
            OpJ:        w_state_next = StJump;
            OpAddi:     w_state_next = StAddiEx;
            default:    Illegal      = 1'b1;
          endcase
        end
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (w_hi_zero && (w_op == OpLw))      w_state_next = StMemRd;
        else if (w_hi_zero && (w_op == OpSw)) w_state_next = StMemWr;
        else                                  w_state_next = StFetch;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (w_last) w_state_next = StMemWb;
        else        w_cnt_next   = r_cnt + 4'd1;
      end
      StMemWb: begin
        RegWrite     = 1'b1;
        MemtoReg     = 1'b1;
        InstrDone    = 1'b1;
        w_state_next = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (w_last) begin
          InstrDone    = 1'b1;
          w_state_next = StFetch;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StExec: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b10;
        w_state_next = StRwb;
      end
      StRwb: begin
        RegWrite     = 1'b1;
        RegDst       = 1'b1;
        InstrDone    = 1'b1;
        w_state_next = StFetch;
      end
      StBeq, StBne: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b01;
        PCWriteCond  = 1'b1;
        PCSource     = 2'b01;
        InstrDone    = 1'b1;
        BranchNe     = (r_state == StBne);
        w_state_next = StFetch;
      end
      StJump: begin
        PCWrite      = 1'b1;
        PCSource     = 2'b10;
        InstrDone    = 1'b1;
        w_state_next = StFetch;
      end
      StAddiEx: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = StAddiWb;
      end
      StAddiWb: begin
        RegWrite     = 1'b1;
        InstrDone    = 1'b1;
        w_state_next = StFetch;
      end
      default: w_state_next = StFetch;
    endcase

    if (!rst_n) begin
      {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
       RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal, State} = '0;
    end
  end

endmodule
